// File: rtl/match_controller_if.sv
// Signal bundle between match_controller and its surroundings (graphics, ball mover, display, sound).
// The slave side is the controller itself; master is whatever drives the frame/miss/joystick inputs.
interface match_controller_if;
   logic       endofframe;
   logic [1:0] missed;
   logic       is_moving;
   logic       restart;
   logic [7:0] score_p1;
   logic [7:0] score_p2;
   logic [1:0] point_pulse;
   logic       game_over;
   logic [1:0] winner;

   modport slave (
      input  endofframe, missed, is_moving,
      output restart, score_p1, score_p2, point_pulse, game_over, winner
   );

   modport master (
      output endofframe, missed, is_moving,
      input  restart, score_p1, score_p2, point_pulse, game_over, winner
   );
endinterface

// File: rtl/match_controller.sv
// Match sequencer: turns per-frame border misses into single scoring events, keeps BCD scores,
// drives the ball restart line and holds a timed game-over state before returning to idle.
module match_controller #(
   parameter int WIN_SCORE    = 11,
   parameter int SERVE_FRAMES = 60,
   parameter int OVER_FRAMES  = 180
) (
   input  logic               clk50M,
   input  logic               reset_n,
   match_controller_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

   localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
   localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES);

   state_t     r_state;
   logic       r_eof_q;
   logic [1:0] r_miss_q;
   logic [7:0] r_timer;
   logic       r_restart;
   logic       r_game_over;
   logic [7:0] r_score_p1;
   logic [7:0] r_score_p2;
   logic [1:0] r_point_pulse;
   logic [1:0] r_winner;

   logic       w_tick;
   logic [1:0] w_miss_evt;
   logic [7:0] w_timer_dec;
   logic [7:0] w_p1_inc;
   logic [7:0] w_p2_inc;

   // Two-digit BCD increment that sticks at 99 instead of wrapping.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign w_tick      = bus.endofframe & ~r_eof_q;
   assign w_miss_evt  = w_tick ? (bus.missed & ~r_miss_q) : 2'b00;
   assign w_timer_dec = (w_tick && (r_timer != 8'd0)) ? (r_timer - 8'd1) : r_timer;
   assign w_p1_inc    = bcd_inc(r_score_p1);
   assign w_p2_inc    = bcd_inc(r_score_p2);

   always_ff @(posedge clk50M) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_eof_q       <= 1'b0;
         r_miss_q      <= 2'b00;
         r_timer       <= 8'd0;
         r_restart     <= 1'b1;
         r_game_over   <= 1'b0;
         r_score_p1    <= 8'h00;
         r_score_p2    <= 8'h00;
         r_point_pulse <= 2'b00;
         r_winner      <= 2'b00;
      end else begin
         r_eof_q       <= bus.endofframe;
         r_point_pulse <= 2'b00;
         r_timer       <= w_timer_dec;
         if (w_tick)
            r_miss_q <= bus.missed;

         case (r_state)
            S_IDLE: begin
               r_score_p1  <= 8'h00;
               r_score_p2  <= 8'h00;
               r_winner    <= 2'b00;
               r_restart   <= 1'b1;
               r_game_over <= 1'b0;
               if (bus.is_moving) begin
                  r_state <= S_SERVE;
                  r_timer <= SERVE_LOAD;
               end
            end
            S_SERVE: begin
               if ((r_timer == 8'd0) && bus.is_moving) begin
                  r_state   <= S_PLAY;
                  r_restart <= 1'b0;
               end
            end
            S_PLAY: begin
               // A simultaneous hit on both borders is treated as a void rally.
               case (w_miss_evt)
                  2'b11: begin
                     r_state   <= S_SERVE;
                     r_timer   <= SERVE_LOAD;
                     r_restart <= 1'b1;
                  end
                  2'b10: begin
                     r_score_p1       <= w_p1_inc;
                     r_point_pulse[0] <= 1'b1;
                     r_restart        <= 1'b1;
                     if (w_p1_inc == WIN_BCD) begin
                        r_state     <= S_OVER;
                        r_timer     <= OVER_LOAD;
                        r_winner    <= 2'b01;
                        r_game_over <= 1'b1;
                     end else begin
                        r_state <= S_SERVE;
                        r_timer <= SERVE_LOAD;
                     end
                  end
                  2'b01: begin
                     r_score_p2       <= w_p2_inc;
                     r_point_pulse[1] <= 1'b1;
                     r_restart        <= 1'b1;
                     if (w_p2_inc == WIN_BCD) begin
                        r_state     <= S_OVER;
                        r_timer     <= OVER_LOAD;
                        r_winner    <= 2'b10;
                        r_game_over <= 1'b1;
                     end else begin
                        r_state <= S_SERVE;
                        r_timer <= SERVE_LOAD;
                     end
                  end
                  default: ;
               endcase
            end
            S_OVER: begin
               if (r_timer == 8'd0) begin
                  r_state     <= S_IDLE;
                  r_score_p1  <= 8'h00;
                  r_score_p2  <= 8'h00;
                  r_winner    <= 2'b00;
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.restart     = r_restart;
   assign bus.game_over   = r_game_over;
   assign bus.score_p1    = r_score_p1;
   assign bus.score_p2    = r_score_p2;
   assign bus.point_pulse = r_point_pulse;
   assign bus.winner      = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short serve/over timers; inputs change and outputs
// are sampled on the falling clock edge.
module tb_match_controller;

   logic clk50M;
   logic reset_n;
   int   n_vec;
   int   n_miscmp;
   int   n_pp0;
   int   n_pp1;

   match_controller_if bus ();

   match_controller #(
      .WIN_SCORE   (11),
      .SERVE_FRAMES(3),
      .OVER_FRAMES (4)
   ) u_dut (
      .clk50M (clk50M),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk50M = 1'b0;
   always #10 clk50M = ~clk50M;

   // Pulse-width tally: every falling edge with a pulse high adds one.
   always @(negedge clk50M) begin
      if (bus.point_pulse[0]) n_pp0 = n_pp0 + 1;
      if (bus.point_pulse[1]) n_pp1 = n_pp1 + 1;
   end

   task automatic check_vec(input string tag, input int obs, input int exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_miscmp = n_miscmp + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frame_hi(input logic [1:0] m);
      bus.missed     = m;
      bus.endofframe = 1'b1;
      @(negedge clk50M);
   endtask

   task automatic frame_lo();
      bus.endofframe = 1'b0;
      @(negedge clk50M);
   endtask

   task automatic frame(input logic [1:0] m);
      frame_hi(m);
      frame_lo();
   endtask

   // One point for the given side starting in PLAY, then serve back into PLAY.
   task automatic score_once(input logic [1:0] m);
      frame(m);
      for (int i = 0; i < 3; i++) frame(2'b00);
   endtask

   initial begin
      n_vec          = 0;
      n_miscmp       = 0;
      n_pp0          = 0;
      n_pp1          = 0;
      reset_n        = 1'b0;
      bus.endofframe = 1'b0;
      bus.missed     = 2'b00;
      bus.is_moving  = 1'b0;
      repeat (3) @(negedge clk50M);
      reset_n = 1'b1;

      // T1: reset state and idling
      check_vec("rst_restart", bus.restart, 1);
      check_vec("rst_p1", bus.score_p1, 8'h00);
      check_vec("rst_p2", bus.score_p2, 8'h00);
      check_vec("rst_over", bus.game_over, 0);
      check_vec("rst_winner", bus.winner, 2'b00);
      check_vec("rst_pulse", bus.point_pulse, 2'b00);
      repeat (4) @(negedge clk50M);
      frame(2'b10);
      frame(2'b00);
      check_vec("idle_restart", bus.restart, 1);
      check_vec("idle_p1", bus.score_p1, 8'h00);
      check_vec("idle_pulses", n_pp0 + n_pp1, 0);

      // T2: serve lasts three ticks, restart drops on PLAY entry
      bus.is_moving = 1'b1;
      @(negedge clk50M);
      frame(2'b00);
      check_vec("serve_f1", bus.restart, 1);
      frame(2'b00);
      check_vec("serve_f2", bus.restart, 1);
      frame_hi(2'b00);
      check_vec("serve_tick3", bus.restart, 1);
      frame_lo();
      check_vec("play_entry", bus.restart, 0);

      // T3: P1 point with the ball dwelling on the right border for 5 frames
      frame_hi(2'b10);
      check_vec("t3_pulse", bus.point_pulse, 2'b01);
      check_vec("t3_p1_now", bus.score_p1, 8'h01);
      check_vec("t3_serve", bus.restart, 1);
      frame_lo();
      check_vec("t3_pulse_off", bus.point_pulse, 2'b00);
      for (int i = 0; i < 4; i++) frame(2'b10);
      check_vec("t3_p1", bus.score_p1, 8'h01);
      check_vec("t3_p2", bus.score_p2, 8'h00);
      check_vec("t3_pp0_cnt", n_pp0, 1);
      check_vec("t3_play", bus.restart, 0);
      frame(2'b00);

      // T4: BCD carry, win, game-over hold and return to idle
      score_once(2'b01);
      check_vec("t4_p2", bus.score_p2, 8'h01);
      check_vec("t4_pp1_cnt", n_pp1, 1);
      for (int i = 0; i < 8; i++) score_once(2'b10);
      check_vec("t4_p1_09", bus.score_p1, 8'h09);
      score_once(2'b10);
      check_vec("t4_p1_10", bus.score_p1, 8'h10);
      check_vec("t4_not_over", bus.game_over, 0);
      frame_hi(2'b10);
      check_vec("t4_p1_11", bus.score_p1, 8'h11);
      check_vec("t4_over", bus.game_over, 1);
      check_vec("t4_winner", bus.winner, 2'b01);
      check_vec("t4_restart", bus.restart, 1);
      frame_lo();
      bus.is_moving = 1'b0;
      for (int i = 0; i < 3; i++) frame(2'b00);
      check_vec("t4_hold_over", bus.game_over, 1);
      check_vec("t4_hold_p1", bus.score_p1, 8'h11);
      check_vec("t4_hold_win", bus.winner, 2'b01);
      frame(2'b00);
      check_vec("t4_idle_over", bus.game_over, 0);
      check_vec("t4_idle_p1", bus.score_p1, 8'h00);
      check_vec("t4_idle_p2", bus.score_p2, 8'h00);
      check_vec("t4_idle_win", bus.winner, 2'b00);
      check_vec("t4_idle_rst", bus.restart, 1);
      check_vec("t4_pp0_cnt", n_pp0, 11);

      // T5: both borders on one tick voids the rally
      bus.is_moving = 1'b1;
      @(negedge clk50M);
      for (int i = 0; i < 3; i++) frame(2'b00);
      check_vec("t5_play", bus.restart, 0);
      score_once(2'b10);
      check_vec("t5_p1", bus.score_p1, 8'h01);
      frame_hi(2'b11);
      check_vec("t5_pulse", bus.point_pulse, 2'b00);
      check_vec("t5_serve", bus.restart, 1);
      frame_lo();
      check_vec("t5_p1_keep", bus.score_p1, 8'h01);
      check_vec("t5_p2_keep", bus.score_p2, 8'h00);
      check_vec("t5_pp1_cnt", n_pp1, 1);
      for (int i = 0; i < 3; i++) frame(2'b00);
      check_vec("t5_replay", bus.restart, 0);

      // T6: one-clock reset in the middle of play
      for (int i = 0; i < 7; i++) score_once(2'b01);
      check_vec("t6_p2_07", bus.score_p2, 8'h07);
      check_vec("t6_play", bus.restart, 0);
      reset_n       = 1'b0;
      bus.is_moving = 1'b0;
      @(negedge clk50M);
      reset_n = 1'b1;
      check_vec("t6_restart", bus.restart, 1);
      check_vec("t6_p2", bus.score_p2, 8'h00);
      check_vec("t6_p1", bus.score_p1, 8'h00);
      frame(2'b01);
      check_vec("t6_idle_p2", bus.score_p2, 8'h00);
      check_vec("t6_idle_rst", bus.restart, 1);
      check_vec("t6_pp1_cnt", n_pp1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
